// File: rtl/wconv_fifo_pkg.sv
// Shared configuration helpers for the width-converting FIFO: width
// derivation, ratio calculation and the parameter sanity check.
package wconv_fifo_pkg;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Narrow unit width: the smaller of the two port widths.
    function automatic int unsigned calc_dwn(input int unsigned dwi, input int unsigned dwo);
        return (dwi < dwo) ? dwi : dwo;
    endfunction

    // Narrow units per write word.
    function automatic int unsigned calc_ri(input int unsigned dwi, input int unsigned dwo);
        return dwi / calc_dwn(dwi, dwo);
    endfunction

    // Narrow units per read word.
    function automatic int unsigned calc_ro(input int unsigned dwi, input int unsigned dwo);
        return dwo / calc_dwn(dwi, dwo);
    endfunction

    // Number of RAM banks: the larger of the two ratios.
    function automatic int unsigned calc_ratio(input int unsigned dwi, input int unsigned dwo);
        return (calc_ri(dwi, dwo) > calc_ro(dwi, dwo)) ? calc_ri(dwi, dwo) : calc_ro(dwi, dwo);
    endfunction

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

    // Widths must be exact power-of-2 multiples and the depth must hold one wide word.
    function automatic bit cfg_ok(input int unsigned dwi, input int unsigned dwo,
                                  input int unsigned awn);
        int unsigned dwn;
        dwn = calc_dwn(dwi, dwo);
        return (dwn != 0) && (dwi % dwn == 0) && (dwo % dwn == 0) &&
               is_pow2(calc_ratio(dwi, dwo)) && (awn >= clog2(calc_ratio(dwi, dwo)));
    endfunction

endpackage

// File: rtl/wconv_ram.sv
// Banked simple dual-port storage for the width-converting FIFO.
// One DWN-wide bank per narrow lane of the wider port; pointers are in
// narrow units, low bits pick the bank and high bits the row.
module wconv_ram
    import wconv_fifo_pkg::*;
#(
    parameter int unsigned DWI = 16,
    parameter int unsigned DWO = 64,
    parameter int unsigned AWN = 7
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           we_i,
    input  logic [AWN-1:0] wptr_i,
    input  logic [DWI-1:0] wdata_i,
    input  logic           re_i,
    input  logic [AWN-1:0] rptr_i,
    output logic [DWO-1:0] rdata_o
);

    localparam int unsigned DWN   = calc_dwn(DWI, DWO);
    localparam int unsigned RI    = calc_ri(DWI, DWO);
    localparam int unsigned RO    = calc_ro(DWI, DWO);
    localparam int unsigned RATIO = calc_ratio(DWI, DWO);
    localparam int unsigned LR    = clog2(RATIO);
    localparam int unsigned LRX   = (LR > 0) ? LR : 1;
    localparam int unsigned AWB   = AWN - LR;
    localparam int unsigned AWBX  = (AWB > 0) ? AWB : 1;
    localparam int unsigned DEPTH = 1 << AWB;

    logic [DWN-1:0]  mem_q [RATIO][DEPTH];
    logic [DWN-1:0]  wlane [RATIO];
    logic [DWN-1:0]  rbank_data [RATIO];
    logic [AWBX-1:0] waddr;
    logic [AWBX-1:0] raddr;
    logic [LRX-1:0]  wbank;
    logic [LRX-1:0]  rbank;
    logic [DWO-1:0]  rdata_d;
    logic [DWO-1:0]  rdata_q;

    assign waddr = AWBX'(wptr_i >> LR);
    assign raddr = AWBX'(rptr_i >> LR);
    assign wbank = LRX'(wptr_i);
    assign rbank = LRX'(rptr_i);

    // Split a wide write word across all banks, or broadcast a narrow one.
    if (RI == RATIO) begin : g_wsplit
        for (genvar b = 0; b < RATIO; b++) begin : g_lane
            assign wlane[b] = wdata_i[b*DWN +: DWN];
        end
    end else begin : g_wbcast
        for (genvar b = 0; b < RATIO; b++) begin : g_lane
            assign wlane[b] = wdata_i[DWN-1:0];
        end
    end

    // Write all banks for a wide write, only the addressed bank for a narrow one.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int unsigned b = 0; b < RATIO; b++) begin
                if ((RI == RATIO) || (LRX'(b) == wbank)) mem_q[b][waddr] <= wlane[b];
            end
        end
    end

    // Asynchronous bank read at the shared row address.
    always_comb begin
        for (int unsigned b = 0; b < RATIO; b++) begin
            rbank_data[b] = mem_q[b][raddr];
        end
    end

    // Wide read concatenates banks little-endian; narrow read muxes one bank.
    if (RO == RATIO) begin : g_rcat
        logic rbank_unused;
        assign rbank_unused = ^rbank;
        for (genvar b = 0; b < RATIO; b++) begin : g_lane
            assign rdata_d[b*DWN +: DWN] = rbank_data[b];
        end
    end else begin : g_rmux
        assign rdata_d = rbank_data[rbank];
    end

    // Output register updates only on an accepted read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rdata_q <= '0;
        else if (re_i) rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_wconv_fifo.sv
// Single-clock FIFO with independent write/read widths (up- or downsizing),
// level output, programmable thresholds and sticky error flags.
module sync_wconv_fifo
    import wconv_fifo_pkg::*;
#(
    parameter int unsigned DWI = 16,
    parameter int unsigned DWO = 64,
    parameter int unsigned AWN = 7
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           winc,
    input  logic [DWI-1:0] wdata,
    output logic           wfull,
    input  logic           rinc,
    output logic [DWO-1:0] rdata,
    output logic           rempty,
    output logic [AWN:0]   level,
    input  logic [AWN:0]   prog_full_th,
    output logic           prog_full,
    input  logic [AWN:0]   prog_empty_th,
    output logic           prog_empty,
    input  logic           clr_err,
    output logic           overflow,
    output logic           underflow
);

    localparam int unsigned RI = calc_ri(DWI, DWO);
    localparam int unsigned RO = calc_ro(DWI, DWO);

    if (!cfg_ok(DWI, DWO, AWN)) begin : g_cfg_err
        $error("sync_wconv_fifo: unsupported DWI/DWO/AWN combination");
    end

    localparam logic [AWN:0]   RI_P = (AWN+1)'(RI);
    localparam logic [AWN:0]   RO_P = (AWN+1)'(RO);
    localparam logic [AWN+1:0] RI_E = (AWN+2)'(RI);
    localparam logic [AWN+1:0] CAP  = (AWN+2)'(1) << AWN;

    logic [AWN:0]   wptr_q, wptr_d;
    logic [AWN:0]   rptr_q, rptr_d;
    logic [AWN:0]   level_q, level_d;
    logic           ovf_q, ovf_d;
    logic           unf_q, unf_d;
    logic [AWN+1:0] free_w;
    logic           wacc;
    logic           racc;

    // Flags derive from the registered level so they lag the accepted op by one cycle.
    always_comb begin
        free_w     = CAP - {1'b0, level_q};
        wfull      = free_w < RI_E;
        rempty     = level_q < RO_P;
        prog_full  = level_q >= prog_full_th;
        prog_empty = level_q <= prog_empty_th;
        wacc       = winc && !wfull;
        racc       = rinc && !rempty;
    end

    // Next-state for pointers, level and sticky errors; a set beats a same-cycle clear.
    always_comb begin
        wptr_d  = wptr_q + (wacc ? RI_P : '0);
        rptr_d  = rptr_q + (racc ? RO_P : '0);
        level_d = wptr_d - rptr_d;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (clr_err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (winc && wfull) ovf_d = 1'b1;
        if (rinc && rempty) unf_d = 1'b1;
    end

    // Control state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    wconv_ram #(
        .DWI (DWI),
        .DWO (DWO),
        .AWN (AWN)
    ) u_ram (
        .clk_i   (clk),
        .rst_ni  (rstn),
        .we_i    (wacc),
        .wptr_i  (wptr_q[AWN-1:0]),
        .wdata_i (wdata),
        .re_i    (racc),
        .rptr_i  (rptr_q[AWN-1:0]),
        .rdata_o (rdata)
    );

    assign level     = level_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule
